mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 148 ++++++++++++++
 tb/tb_mul_div_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit: WIDTH+2 cycle latency for every op.
// Divide hardware is present only when MUL_DIV_UNIT_DIV_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | first cycle forms operand magnitudes, then WIDTH radix-2 steps
// FIX    | sign correction, write hi/lo/dbz
// DONE   | result valid for one cycle, may accept a new start
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_m, r_q;
  logic [WIDTH:0]   r_acc;

  logic             w_accept, w_is_div, w_signed, w_sa, w_sb;
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_q_nx, w_hi, w_lo;
  logic [WIDTH:0]   w_msum, w_acc_nx;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic             w_dbz;

  assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
  assign busy     = (r_state == S_RUN) || (r_state == S_FIX);
  assign done     = (r_state == S_DONE);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_RUN;
      S_RUN:  if (r_cnt == '0) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_is_div = r_op[1];
  assign w_signed = ~r_op[0];
  assign w_sa     = w_signed & r_a[WIDTH-1];
  assign w_sb     = w_signed & r_b[WIDTH-1];
  assign w_abs_a  = w_sa ? -r_a : r_a;
  assign w_abs_b  = w_sb ? -r_b : r_b;

  // Multiply: r_m holds |a|, r_q holds |b| and collects the low product half.
  assign w_msum = r_acc + (r_q[0] ? {1'b0, r_m} : '0);

`ifdef MUL_DIV_UNIT_DIV_EN
  logic [WIDTH:0] w_rsh;
  logic           w_rge;
  assign w_rsh = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_rge = (w_rsh >= {1'b0, r_m});
`endif

  always_comb begin
    w_acc_nx = {1'b0, w_msum[WIDTH:1]};
    w_q_nx   = {w_msum[0], r_q[WIDTH-1:1]};
`ifdef MUL_DIV_UNIT_DIV_EN
    if (w_is_div) begin
      w_acc_nx = w_rge ? (w_rsh - {1'b0, r_m}) : w_rsh;
      w_q_nx   = {r_q[WIDTH-2:0], w_rge};
    end
`endif
  end

  assign w_prod     = {r_acc[WIDTH-1:0], r_q};
  assign w_prod_fix = (w_sa ^ w_sb) ? -w_prod : w_prod;

  always_comb begin
    w_hi  = w_prod_fix[2*WIDTH-1:WIDTH];
    w_lo  = w_prod_fix[WIDTH-1:0];
    w_dbz = 1'b0;
    if (w_is_div) begin
`ifdef MUL_DIV_UNIT_DIV_EN
      if (r_b == '0) begin
        w_hi  = r_a;
        w_lo  = '1;
        w_dbz = 1'b1;
      end else begin
        w_lo = (w_sa ^ w_sb) ? -r_q : r_q;
        w_hi = w_sa ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
      end
`else
      w_hi = '0;
      w_lo = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_cnt <= '0;
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_m   <= '0;
      r_q   <= '0;
      r_acc <= '0;
      hi    <= '0;
      lo    <= '0;
      dbz   <= 1'b0;
    end else if (w_accept) begin
      r_op  <= op;
      r_a   <= a;
      r_b   <= b;
      r_cnt <= CNT_INIT;
    end else if (r_state == S_RUN) begin
      if (r_cnt == CNT_INIT) begin
        r_acc <= '0;
        r_m   <= w_is_div ? w_abs_b : w_abs_a;
        r_q   <= w_is_div ? w_abs_a : w_abs_b;
      end else begin
        r_acc <= w_acc_nx;
        r_q   <= w_q_nx;
      end
      r_cnt <= r_cnt - 1'b1;
    end else if (r_state == S_FIX) begin
      hi  <= w_hi;
      lo  <= w_lo;
      dbz <= w_dbz;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected results come from plain 64-bit arithmetic.
module tb_mul_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0, clr = 1'b0, start = 1'b0;
  logic [1:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic [W-1:0] hi, lo;
  logic         busy, done, dbz;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t last;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .dbz(dbz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   e;
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.dbz = 1'b0;
    e.cyc = 0;
    case (o)
      2'b00: begin p = sx * sy; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b01: begin p = {32'b0, x} * {32'b0, y}; e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
`ifdef MUL_DIV_UNIT_DIV_EN
        if (y == '0) begin
          e.hi = x; e.lo = '1; e.dbz = 1'b1;
        end else if (o == 2'b10) begin
          q = sx / sy; r = sx % sy;
          e.lo = q[31:0]; e.hi = r[31:0];
        end else begin
          e.lo = x / y; e.hi = x % y;
        end
`else
        e.hi = '0; e.lo = '0;
`endif
      end
    endcase
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (clr && done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 64'(done), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("hi", 64'(hi), 64'(e.hi));
        chk("lo", 64'(lo), 64'(e.lo));
        chk("dbz", 64'(dbz), 64'(e.dbz));
        chk("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Called at a falling edge; the request is accepted on the next rising edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int tdone);
    exp_t e;
    e = model(o, x, y);
    e.cyc = cyc + 1 + W + 2;
    tdone = e.cyc;
    sb.push_back(e);
    last = e;
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("done_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic wait_until(input int t);
    for (int i = 0; i < 200 && cyc < t; i++) @(negedge clk);
    chk("reach_done_cycle", 64'(cyc), 64'(t));
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int t;
    issue(o, x, y, t);
    wait_done();
  endtask

  initial begin
    int t;
    logic [W-1:0] specials [5];
    specials[0] = 32'h0;
    specials[1] = 32'h8000_0000;
    specials[2] = 32'hFFFF_FFFF;
    specials[3] = 32'h1;
    specials[4] = 32'h7FFF_FFFF;

    #1;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dbz", 64'(dbz), 64'd0);
    @(negedge clk);
    clr = 1'b1;

    run_op(2'b01, 32'h12, 32'h14);
    chk("hold_lo", 64'(lo), 64'(last.lo));
    run_op(2'b00, 32'hFFFF_FFFD, 32'h7);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h2);
    run_op(2'b11, 32'h18, 32'h0);
    chk("hold_dbz", 64'(dbz), 64'(last.dbz));
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b10, 32'h18, 32'h4);
    run_op(2'b10, 32'h8000_0000, 32'h0);

    // Start while busy is ignored; start in DONE is accepted back-to-back.
    issue(2'b01, 32'd5, 32'd6, t);
    repeat (8) @(negedge clk);
    chk("busy_mid", 64'(busy), 64'd1);
    op = 2'b01; a = 32'd9; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(t);
    issue(2'b01, 32'd2, 32'd3, t);
    wait_done();
    chk("b2b_lo", 64'(lo), 64'h6);

    // Reset in the middle of a multiply.
    issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, t);
    repeat (13) @(negedge clk);
    #2 clr = 1'b0;
    #1;
    chk("mid_rst_hi", 64'(hi), 64'd0);
    chk("mid_rst_lo", 64'(lo), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_dbz", 64'(dbz), 64'd0);
    sb.delete();
    @(negedge clk);
    clr = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_idle", 64'(busy), 64'd0);
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    run_op(2'b01, 32'h12, 32'h14);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]   o;
      logic [W-1:0] x, y;
      o = 2'($urandom_range(0, 3));
      x = ($urandom_range(0, 4) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      y = ($urandom_range(0, 4) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 2) == 0) y = W'($urandom_range(1, 20));
      issue(o, x, y, t);
      if ($urandom_range(0, 2) == 0) begin
        wait_until(t);
        issue(2'($urandom_range(0, 3)), $urandom, $urandom, t);
      end
      wait_done();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
